// File: rtl/tcdm_init_pkg.sv
// Shared types for the TCDM initiator shim: request metadata and AMO codes.
// Optional in-order response buffer is enabled with TCDM_INITIATOR_ROB_EN.
package tcdm_init_pkg;

  localparam int unsigned META_CORE_ID_W = 8;
  localparam int unsigned META_TAG_W = 4;
  localparam int unsigned TCDM_STORE_FLAG = 0;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_XOR  = 4'h3,
    AMO_AND  = 4'h4,
    AMO_OR   = 4'h5,
    AMO_MIN  = 4'h6,
    AMO_MAX  = 4'h7,
    AMO_MINU = 4'h8,
    AMO_MAXU = 4'h9,
    AMO_LR   = 4'hA,
    AMO_SC   = 4'hB
  } tcdm_amo_e;

  typedef struct packed {
    logic [META_CORE_ID_W-1:0] core_id;
    logic [META_TAG_W-1:0]     tag;
    logic                      is_store;
  } tcdm_init_meta_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/tcdm_init_rob.sv
// Reorder buffer: one slot per tag, drained strictly in grant order.
// Built only when TCDM_INITIATOR_ROB_EN is defined.
module tcdm_init_rob
  import tcdm_init_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 4,
  localparam int unsigned TagWidth      = idx_width(NumOutstanding)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 resp_valid_i,
  input  logic [TagWidth-1:0]  resp_tag_i,
  input  logic                 resp_store_i,
  input  logic [DataWidth-1:0] resp_rdata_i,
  output logic                 core_rvalid_o,
  input  logic                 core_rready_i,
  output logic [DataWidth-1:0] core_rdata_o,
  output logic                 retire_o
);

  logic [NumOutstanding-1:0] slot_valid_q;
  logic [NumOutstanding-1:0] slot_store_q;
  logic [DataWidth-1:0]      slot_data_q [NumOutstanding];
  logic [TagWidth-1:0]       retire_ptr_q;
  logic                      head_valid;
  logic                      head_store;

  assign head_valid    = slot_valid_q[retire_ptr_q];
  assign head_store    = slot_store_q[retire_ptr_q];
  assign core_rvalid_o = head_valid && !head_store;
  assign core_rdata_o  = slot_data_q[retire_ptr_q];
  assign retire_o      = head_valid && (head_store || core_rready_i);

  // Free the head on retire, then capture any arriving response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= '0;
      slot_store_q <= '0;
      retire_ptr_q <= '0;
      for (int i = 0; i < NumOutstanding; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      if (retire_o) begin
        slot_valid_q[retire_ptr_q] <= 1'b0;
        retire_ptr_q <= retire_ptr_q + 1'b1;
      end
      if (resp_valid_i) begin
        slot_valid_q[resp_tag_i] <= 1'b1;
        slot_store_q[resp_tag_i] <= resp_store_i;
        slot_data_q[resp_tag_i]  <= resp_rdata_i;
      end
    end
  end

endmodule

// File: rtl/tcdm_initiator_shim.sv
// Core req/gnt to TCDM valid/ready initiator with credit-limited issue.
// Define TCDM_INITIATOR_ROB_EN to return responses in issue order.
module tcdm_initiator_shim
  import tcdm_init_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned CoreIdWidth    = 8,
  localparam int unsigned TagWidth      = idx_width(NumOutstanding)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CoreIdWidth-1:0] core_id_i,
  input  logic                   core_req_i,
  output logic                   core_gnt_o,
  input  logic [AddrWidth-1:0]   core_addr_i,
  input  logic [3:0]             core_amo_i,
  input  logic                   core_write_i,
  input  logic [DataWidth-1:0]   core_wdata_i,
  input  logic [DataWidth/8-1:0] core_be_i,
  output logic                   core_rvalid_o,
  input  logic                   core_rready_i,
  output logic [DataWidth-1:0]   core_rdata_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [AddrWidth-1:0]   req_addr_o,
  output logic [3:0]             req_amo_o,
  output logic                   req_write_o,
  output logic [DataWidth-1:0]   req_wdata_o,
  output logic [DataWidth/8-1:0] req_be_o,
  output tcdm_init_meta_t        req_meta_o,
  input  logic                   resp_valid_i,
  output logic                   resp_ready_o,
  input  logic [DataWidth-1:0]   resp_rdata_i,
  input  tcdm_init_meta_t        resp_meta_i
);

  localparam int unsigned CntWidth = TagWidth + 1;

  logic [CntWidth-1:0]       outstanding_q;
  logic [TagWidth-1:0]       alloc_ptr_q;
  logic [NumOutstanding-1:0] inflight_q;
  logic                      credit_avail;
  logic                      grant;
  logic                      retire;
  logic                      resp_acc;
  logic                      resp_store;
  logic [TagWidth-1:0]       resp_tag;
  logic                      unused_meta;

  assign credit_avail = outstanding_q != CntWidth'(NumOutstanding);
  assign req_valid_o  = !rst_i && core_req_i && credit_avail;
  assign grant        = req_valid_o && req_ready_i;
  assign core_gnt_o   = grant;

  assign req_addr_o  = core_addr_i;
  assign req_amo_o   = core_amo_i;
  assign req_write_o = core_write_i;
  assign req_wdata_o = core_wdata_i;
  assign req_be_o    = core_be_i;

  // Tag the request; metadata reads as zero while in reset.
  always_comb begin
    req_meta_o = '0;
    if (!rst_i) begin
      req_meta_o.core_id  = META_CORE_ID_W'(core_id_i);
      req_meta_o.tag      = META_TAG_W'(alloc_ptr_q);
      req_meta_o.is_store = core_write_i && (core_amo_i == AMO_NONE);
    end
  end

  assign resp_store  = resp_meta_i[TCDM_STORE_FLAG];
  assign resp_tag    = resp_meta_i.tag[TagWidth-1:0];
  assign resp_acc    = resp_valid_i && resp_ready_o;
  assign unused_meta = ^{resp_meta_i.core_id, resp_meta_i.tag};

`ifdef TCDM_INITIATOR_ROB_EN
  logic                 rob_rvalid;
  logic [DataWidth-1:0] rob_rdata;

  tcdm_init_rob #(
    .DataWidth      (DataWidth),
    .NumOutstanding (NumOutstanding)
  ) i_rob (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .resp_valid_i  (resp_acc),
    .resp_tag_i    (resp_tag),
    .resp_store_i  (resp_store),
    .resp_rdata_i  (resp_rdata_i),
    .core_rvalid_o (rob_rvalid),
    .core_rready_i (core_rready_i),
    .core_rdata_o  (rob_rdata),
    .retire_o      (retire)
  );

  assign resp_ready_o  = !rst_i;
  assign core_rvalid_o = !rst_i && rob_rvalid;
  assign core_rdata_o  = rst_i ? '0 : rob_rdata;
`else
  assign resp_ready_o  = !rst_i && (core_rready_i || resp_store);
  assign core_rvalid_o = !rst_i && resp_valid_i && !resp_store;
  assign core_rdata_o  = rst_i ? '0 : resp_rdata_i;
  assign retire        = resp_acc;
`endif

  // Credit count: grant adds, retire removes, both cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      unique case ({grant, retire})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Round-robin tag allocation and in-flight tag tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr_q <= '0;
      inflight_q  <= '0;
    end else begin
      if (resp_acc) inflight_q[resp_tag] <= 1'b0;
      if (grant) begin
        alloc_ptr_q             <= alloc_ptr_q + 1'b1;
        inflight_q[alloc_ptr_q] <= 1'b1;
      end
    end
  end

  resp_tag_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i)
    resp_acc |-> inflight_q[resp_tag]
  );

endmodule

// File: tb/tb_tcdm_initiator_shim.sv
// Directed bench for tcdm_initiator_shim, bypass or reorder build.
// Expectations follow TCDM_INITIATOR_ROB_EN when it is defined.
module tb_tcdm_initiator_shim;
  import tcdm_init_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [7:0]      core_id_i = 8'h5A;
  logic            core_req_i = 1'b0;
  logic            core_gnt_o;
  logic [31:0]     core_addr_i = '0;
  logic [3:0]      core_amo_i = '0;
  logic            core_write_i = 1'b0;
  logic [31:0]     core_wdata_i = '0;
  logic [3:0]      core_be_i = 4'hF;
  logic            core_rvalid_o;
  logic            core_rready_i = 1'b1;
  logic [31:0]     core_rdata_o;
  logic            req_valid_o;
  logic            req_ready_i = 1'b1;
  logic [31:0]     req_addr_o;
  logic [3:0]      req_amo_o;
  logic            req_write_o;
  logic [31:0]     req_wdata_o;
  logic [3:0]      req_be_o;
  tcdm_init_meta_t req_meta_o;
  logic            resp_valid_i = 1'b0;
  logic            resp_ready_o;
  logic [31:0]     resp_rdata_i = '0;
  tcdm_init_meta_t resp_meta_i = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] rv_log [$];

  tcdm_initiator_shim dut (
    .clk_i(clk_i), .rst_i(rst_i), .core_id_i(core_id_i),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_addr_i(core_addr_i), .core_amo_i(core_amo_i),
    .core_write_i(core_write_i), .core_wdata_i(core_wdata_i),
    .core_be_i(core_be_i), .core_rvalid_o(core_rvalid_o),
    .core_rready_i(core_rready_i), .core_rdata_o(core_rdata_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_amo_o(req_amo_o),
    .req_write_o(req_write_o), .req_wdata_o(req_wdata_o),
    .req_be_o(req_be_o), .req_meta_o(req_meta_o),
    .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
    .resp_rdata_i(resp_rdata_i), .resp_meta_i(resp_meta_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i)
    if (!rst_i && core_rvalid_o && core_rready_i)
      rv_log.push_back(core_rdata_o);

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    core_req_i = 1'b0;
    resp_valid_i = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w,
                           input logic [3:0] amo);
    core_req_i = 1'b1;
    core_addr_i = a;
    core_write_i = w;
    core_amo_i = amo;
    core_wdata_i = a ^ 32'h5555_0000;
  endtask

  task automatic drive_resp(input int tag, input logic st,
                            input logic [31:0] d);
    resp_valid_i = 1'b1;
    resp_meta_i = '0;
    resp_meta_i.tag = 4'(tag);
    resp_meta_i.is_store = st;
    resp_rdata_i = d;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    core_rready_i = 1'b1;
    req_ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic drain(input int start, input int n);
    core_rready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive_resp((start + i) % 4, 1'b0, 32'hC0DE_0000 | i);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_req(32'h40, 1'b0, 4'h0);
    drive_resp(0, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (req_valid_o !== 1'b0) begin
        bad++; $display("FAIL rst_req_valid got %b want 0", req_valid_o);
      end
      total++;
      if (core_gnt_o !== 1'b0) begin
        bad++; $display("FAIL rst_gnt got %b want 0", core_gnt_o);
      end
      total++;
      if ({core_rvalid_o, resp_ready_o} !== 2'b00) begin
        bad++; $display("FAIL rst_resp got %b%b want 00",
                        core_rvalid_o, resp_ready_o);
      end
      total++;
      if (req_meta_o !== '0 || core_rdata_o !== 32'h0) begin
        bad++; $display("FAIL rst_zero got meta=%h rdata=%h want 0",
                        req_meta_o, core_rdata_o);
      end
    end
    total++;
    if (dut.outstanding_q !== 3'd0) begin
      bad++; $display("FAIL rst_count got %0d want 0", dut.outstanding_q);
    end
    rst_i = 1'b0;
    resp_valid_i = 1'b0;
    #1;
    total++;
    if (core_gnt_o !== 1'b1 || req_meta_o.tag !== 4'd0) begin
      bad++; $display("FAIL rst_first_gnt got gnt=%b tag=%0d want 1/0",
                      core_gnt_o, req_meta_o.tag);
    end
    total++;
    if (req_meta_o.core_id !== 8'h5A) begin
      bad++; $display("FAIL core_id got %h want 5a", req_meta_o.core_id);
    end
    step();
    idle();
    drain(0, 1);
  endtask

  task automatic test_credit();
    int base;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(32'h1000 + 4 * i, 1'b0, 4'h0);
      #1;
      total++;
      if (core_gnt_o !== 1'b1 || req_meta_o.tag !== 4'(i)) begin
        bad++; $display("FAIL credit_issue%0d got gnt=%b tag=%0d want 1/%0d",
                        i, core_gnt_o, req_meta_o.tag, i);
      end
      step();
    end
    drive_req(32'h2000, 1'b0, 4'h0);
    #1;
    total++;
    if (core_gnt_o !== 1'b0 || req_valid_o !== 1'b0) begin
      bad++; $display("FAIL credit_full got gnt=%b valid=%b want 0/0",
                      core_gnt_o, req_valid_o);
    end
    step();
    base = rv_log.size();
    drive_resp(0, 1'b0, 32'hAAAA_0000);
    #1;
    total++;
    if (core_gnt_o !== 1'b0) begin
      bad++; $display("FAIL credit_resp_cycle got gnt=%b want 0", core_gnt_o);
    end
    step();
    resp_valid_i = 1'b0;
`ifdef TCDM_INITIATOR_ROB_EN
    #1;
    total++;
    if (core_gnt_o !== 1'b0) begin
      bad++; $display("FAIL credit_retire_cycle got gnt=%b want 0",
                      core_gnt_o);
    end
    step();
`endif
    #1;
    total++;
    if (core_gnt_o !== 1'b1 || req_meta_o.tag !== 4'd0) begin
      bad++; $display("FAIL credit_wrap got gnt=%b tag=%0d want 1/0",
                      core_gnt_o, req_meta_o.tag);
    end
    step();
    idle();
    total++;
    if (rv_log.size() != base + 1 || rv_log[base] !== 32'hAAAA_0000) begin
      bad++; $display("FAIL credit_rdata got n=%0d want n=%0d data aaaa0000",
                      rv_log.size() - base, 1);
    end
    drain(1, 4);
    total++;
    if (dut.outstanding_q !== 3'd0) begin
      bad++; $display("FAIL credit_drain got %0d want 0", dut.outstanding_q);
    end
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h3000 + 4 * i, 1'b0, 4'h0);
      step();
    end
    idle();
`ifdef TCDM_INITIATOR_ROB_EN
    drive_resp(2, 1'b0, 32'h22);
    #1;
    total++;
    if (core_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL rob_t2 got rvalid=%b want 0", core_rvalid_o);
    end
    step();
    drive_resp(0, 1'b0, 32'h00);
    #1;
    total++;
    if (core_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL rob_t0 got rvalid=%b want 0", core_rvalid_o);
    end
    step();
    drive_resp(1, 1'b0, 32'h11);
    #1;
    total++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h00) begin
      bad++; $display("FAIL rob_first got rvalid=%b data=%h want 1/0",
                      core_rvalid_o, core_rdata_o);
    end
    step();
    resp_valid_i = 1'b0;
    #1;
    total++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h11) begin
      bad++; $display("FAIL rob_second got rvalid=%b data=%h want 1/11",
                      core_rvalid_o, core_rdata_o);
    end
    step();
    total++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h22) begin
      bad++; $display("FAIL rob_third got rvalid=%b data=%h want 1/22",
                      core_rvalid_o, core_rdata_o);
    end
    step();
    total++;
    if (core_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL rob_empty got rvalid=%b want 0", core_rvalid_o);
    end
`else
    for (int k = 0; k < 3; k++) begin
      int t;
      logic [31:0] d;
      t = (k + 2) % 3;
      d = 32'h11 * t;
      drive_resp(t, 1'b0, d);
      #1;
      total++;
      if (core_rvalid_o !== 1'b1 || core_rdata_o !== d) begin
        bad++; $display("FAIL bypass_t%0d got rvalid=%b data=%h want 1/%h",
                        t, core_rvalid_o, core_rdata_o, d);
      end
      step();
    end
    idle();
    step();
`endif
    total++;
    if (dut.outstanding_q !== 3'd0) begin
      bad++; $display("FAIL order_drain got %0d want 0", dut.outstanding_q);
    end
  endtask

  task automatic test_store_load();
    int base;
    do_reset();
    base = rv_log.size();
    drive_req(32'h100, 1'b1, 4'h0);
    #1;
    total++;
    if (core_gnt_o !== 1'b1 || req_meta_o.is_store !== 1'b1
        || req_write_o !== 1'b1 || req_addr_o !== 32'h100) begin
      bad++; $display("FAIL st_issue got gnt=%b st=%b wr=%b addr=%h want 1/1/1/100",
                      core_gnt_o, req_meta_o.is_store, req_write_o, req_addr_o);
    end
    step();
    drive_req(32'h100, 1'b0, 4'h0);
    #1;
    total++;
    if (req_meta_o.is_store !== 1'b0 || req_meta_o.tag !== 4'd1) begin
      bad++; $display("FAIL ld_issue got st=%b tag=%0d want 0/1",
                      req_meta_o.is_store, req_meta_o.tag);
    end
    step();
    idle();
    core_rready_i = 1'b0;
    drive_resp(0, 1'b1, 32'h0);
    #1;
    total++;
    if (resp_ready_o !== 1'b1 || core_rvalid_o !== 1'b0) begin
      bad++; $display("FAIL st_resp got ready=%b rvalid=%b want 1/0",
                      resp_ready_o, core_rvalid_o);
    end
    step();
    core_rready_i = 1'b1;
    drive_resp(1, 1'b0, 32'hDEAD_BEEF);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    total++;
    if (rv_log.size() != base + 1 || rv_log[base] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL st_ld_rvalid got n=%0d want 1 beat deadbeef",
                      rv_log.size() - base);
    end
    total++;
    if (dut.outstanding_q !== 3'd0) begin
      bad++; $display("FAIL st_ld_count got %0d want 0", dut.outstanding_q);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_req(32'h4000 + 4 * i, 1'b0, 4'h0);
      step();
    end
    idle();
    drive_resp(0, 1'b0, 32'h10);
`ifdef TCDM_INITIATOR_ROB_EN
    step();
    resp_valid_i = 1'b0;
`endif
    drive_req(32'h4008, 1'b0, 4'h0);
    #1;
    total++;
    if (core_gnt_o !== 1'b1 || req_meta_o.tag !== 4'd2
        || core_rvalid_o !== 1'b1) begin
      bad++; $display("FAIL b2b_both got gnt=%b tag=%0d rv=%b want 1/2/1",
                      core_gnt_o, req_meta_o.tag, core_rvalid_o);
    end
    step();
    total++;
    if (dut.outstanding_q !== 3'd2) begin
      bad++; $display("FAIL b2b_count got %0d want 2", dut.outstanding_q);
    end
    core_rready_i = 1'b0;
    drive_resp(1, 1'b0, 32'h11);
    #1;
    total++;
    if (core_gnt_o !== 1'b1 || req_meta_o.tag !== 4'd3) begin
      bad++; $display("FAIL b2b_t3 got gnt=%b tag=%0d want 1/3",
                      core_gnt_o, req_meta_o.tag);
    end
    step();
`ifdef TCDM_INITIATOR_ROB_EN
    resp_valid_i = 1'b0;
`endif
    #1;
    total++;
    if (core_gnt_o !== 1'b1 || req_meta_o.tag !== 4'd0) begin
      bad++; $display("FAIL b2b_t0 got gnt=%b tag=%0d want 1/0",
                      core_gnt_o, req_meta_o.tag);
    end
    step();
    total++;
    if (dut.outstanding_q !== 3'd4 || core_gnt_o !== 1'b0) begin
      bad++; $display("FAIL b2b_full got cnt=%0d gnt=%b want 4/0",
                      dut.outstanding_q, core_gnt_o);
    end
    total++;
    if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h11) begin
      bad++; $display("FAIL b2b_stall got rv=%b data=%h want 1/11",
                      core_rvalid_o, core_rdata_o);
    end
    core_rready_i = 1'b1;
    step();
    idle();
    total++;
    if (dut.outstanding_q !== 3'd3) begin
      bad++; $display("FAIL b2b_release got %0d want 3", dut.outstanding_q);
    end
    drain(2, 3);
    total++;
    if (dut.outstanding_q !== 3'd0) begin
      bad++; $display("FAIL b2b_drain got %0d want 0", dut.outstanding_q);
    end
  endtask

  task automatic test_amo();
    int base;
    do_reset();
    base = rv_log.size();
    drive_req(32'h200, 1'b1, AMO_SC);
    #1;
    total++;
    if (req_amo_o !== 4'hB || req_meta_o.is_store !== 1'b0) begin
      bad++; $display("FAIL sc_issue got amo=%h st=%b want b/0",
                      req_amo_o, req_meta_o.is_store);
    end
    step();
    drive_req(32'h204, 1'b1, AMO_ADD);
    #1;
    total++;
    if (req_amo_o !== 4'h2 || req_meta_o.is_store !== 1'b0) begin
      bad++; $display("FAIL add_issue got amo=%h st=%b want 2/0",
                      req_amo_o, req_meta_o.is_store);
    end
    step();
    idle();
    drive_resp(0, 1'b0, 32'h1);
    step();
    drive_resp(1, 1'b0, 32'h5);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    total++;
    if (rv_log.size() != base + 2) begin
      bad++; $display("FAIL amo_beats got %0d want 2", rv_log.size() - base);
    end else begin
      total++;
      if (rv_log[base] !== 32'h1 || rv_log[base + 1] !== 32'h5) begin
        bad++; $display("FAIL amo_data got %h,%h want 1,5",
                        rv_log[base], rv_log[base + 1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_credit();
    test_order();
    test_store_load();
    test_back_to_back();
    test_amo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tcdm_initiator_shim.md
# tcdm_initiator_shim

Core-side initiator for the TCDM bank interface: converts a core's req/gnt port (loads, stores, AMOs, LR/SC) into valid/ready requests tagged with metadata, and collects the bank responses. Limits outstanding transactions with a credit counter and, optionally, reorders responses into issue order before returning them to the core. Sits between each core's data port and the tile/group interconnect that feeds the bank-side adapters.

## Interface
- AddrWidth, 32, request address width
- DataWidth, 32, data width; only 32 supported
- NumOutstanding, 4, maximum in-flight requests; power of two, ≥2
- CoreIdWidth, 8, width of `core_id_i`
- TagWidth, localparam = idx_width(NumOutstanding); do not override
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `core_id_i`  in  CoreIdWidth  static initiator ID, copied into request metadata
- `core_req_i`  in  1  core request
- `core_gnt_o`  out  1  core grant
- `core_addr_i`  in  AddrWidth  address
- `core_amo_i`  in  4  AMO opcode (0 none … 0xA LR, 0xB SC)
- `core_write_i`  in  1  1 store, 0 load
- `core_wdata_i`  in  DataWidth  write data / AMO operand
- `core_be_i`  in  DataWidth/8  byte enable
- `core_rvalid_o`  out  1  response valid
- `core_rready_i`  in  1  response ready
- `core_rdata_o`  out  DataWidth  response data
- `req_valid_o`  out  1  TCDM request valid
- `req_ready_i`  in  1  TCDM request ready
- `req_addr_o`, `req_amo_o`, `req_write_o`, `req_wdata_o`, `req_be_o`  out  as core side  request fields
- `req_meta_o`  out  tcdm_init_meta_t  {core_id, tag, is_store}
- `resp_valid_i`  in  1  response valid
- `resp_ready_o`  out  1  response ready
- `resp_rdata_i`  in  DataWidth  response data (SC: 0 success, 1 fail)
- `resp_meta_i`  in  tcdm_init_meta_t  echoed metadata

## Operation
- Request path is combinational pass-through: `req_valid_o = core_req_i && credit_avail`; `core_gnt_o = req_valid_o && req_ready_i`; request fields are driven straight from the core inputs.
- `credit_avail = (outstanding_q != NumOutstanding)`.
- Tags are allocated round-robin from `alloc_ptr_q`, which increments mod NumOutstanding on each grant.
- `is_store = core_write_i && core_amo_i == 0`. AMOs, LR and SC all return data.
- `outstanding_q`: +1 on grant, −1 on retire; both in the same cycle → unchanged. Range 0..NumOutstanding.
- Retire = the response leaves the block: either handed to the core, or dropped because it is a store.
- Store responses are never presented to the core. They retire silently and are always accepted.
- Data responses are returned unmodified; the shim does no SC or AMO interpretation.
- A response whose tag is not outstanding is illegal (simulation assertion).

## Timing
- Reset: `core_gnt_o`, `core_rvalid_o`, `req_valid_o`, `resp_ready_o` are 0 during reset. `core_rdata_o` and `req_meta_o` are 0.
- After reset: pointers, count and slot valid bits are 0.
- A reset mid-transaction discards all in-flight state; late responses after reset are not supported.
- Request latency is 0 cycles (same-cycle grant when `req_ready_i`).
- With NumOutstanding requests in flight, `core_gnt_o` is low. A retire in cycle N re-enables grant in cycle N+1 (the count is registered).

## Configuration
- `TCDM_INITIATOR_ROB_EN` defined: in-order reorder buffer.
  - NumOutstanding slots {valid, is_store, data}.
  - `resp_ready_o = 1` always: slots are pre-allocated, so they cannot overflow.
  - A response writes slot[tag]; the slot's valid bit is set at the next clock edge.
  - The head slot (`retire_ptr_q`) is presented on `core_rvalid_o` when valid and not a store. A valid store head retires automatically that cycle.
  - Minimum response latency from `resp_valid_i` to `core_rvalid_o` is 1 cycle.
  - Responses return strictly in grant order.
- Undefined: bypass mode, no storage.
  - `core_rvalid_o = resp_valid_i && !resp_meta_i.is_store`.
  - `core_rdata_o = resp_rdata_i`.
  - `resp_ready_o = core_rready_i || resp_meta_i.is_store`.
  - 0-cycle latency; response order is whatever the network delivers.
  - The credit counter still applies.

## Structure
- Shared package `tcdm_init_pkg`:
  - `tcdm_init_meta_t`
  - the AMO opcode enum (the same encoding the bank adapter uses)
  - `TCDM_STORE_FLAG` constant bit position
- Sub-module `tcdm_init_rob`, instantiated only under `TCDM_INITIATOR_ROB_EN`. It holds the slot array and `retire_ptr_q`.
- The top level holds the credit counter and the allocation pointer.

## Test plan
- Reset with `core_req_i=1`: `req_valid_o=0` and `core_gnt_o=0` throughout reset; grant occurs in the first cycle after `rst_i` falls when `req_ready_i=1`.
- Issue 4 loads with tags 0..3 and no responses: the 5th request sees `core_gnt_o=0`. Respond with tag 0 (0xAAAA0000): the 5th is granted one cycle after retire, with tag 0 (wrap-around).
- ROB_EN: issue loads tags 0, 1, 2; respond in order tag 2 (0x22), then tag 0 (0x00), then tag 1 (0x11). Core sees 0x00, 0x11, 0x22 in order; the first `core_rvalid_o` comes 1 cycle after the tag-0 response.
- Store to 0x100, then load from 0x100 returning 0xDEADBEEF: the core sees exactly one `core_rvalid_o` (0xDEADBEEF), and the outstanding count returns to 0.
- Simultaneous grant and retire with count = 2: the count stays at 2; `core_rready_i=0` stalls the head while new grants continue until the count reaches 4.
- SC response 0x1 (fail) and AMOAdd response 0x5: passed through unchanged as 0x1 and 0x5; `req_amo_o` equals 0xB and 0x2 respectively.
